// File: rtl/root_pkg.sv
// Shared types and constants for the root-engine feeder: widths, FSM states, request record.
package root_pkg;

    localparam int BASE_W = 10;
    localparam int EXP_W  = 3;
    localparam int TAG_W  = 2;
    localparam int RES_W  = 20;
    localparam int CNT_W  = 10;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 1023;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        HOLD
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [EXP_W-1:0]  exp;
        logic [BASE_W-1:0] base;
    } req_t;

endpackage

// File: rtl/root_req_fifo.sv
// Synchronous request queue, zero-latency head read; simultaneous push/pop keeps occupancy.
// Pushes must be gated by !full and pops by !empty at the caller.
module root_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/root_feeder.sv
// Queues root requests and sequences them one at a time through the root engine; issue 1 cycle after pop, result 2 cycles after engine valid.
// req_ready drops when the queue is full; a held result blocks further issue until res_ready.
module root_feeder
    import root_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BASE_W-1:0] req_base,
    input  logic [EXP_W-1:0]  req_exp,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              eng_in_valid,
    output logic [BASE_W-1:0] eng_in_data_1,
    output logic [EXP_W-1:0]  eng_in_data_2,
    input  logic              eng_out_valid,
    input  logic [RES_W-1:0]  eng_out_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_err
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    req_t              push_req;
    req_t              head;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    state_t            state,      state_nxt;
    logic [CNT_W-1:0]  wait_cnt,   wait_cnt_nxt;
    logic [BASE_W-1:0] op_base_nxt;
    logic [EXP_W-1:0]  op_exp_nxt;
    logic [RES_W-1:0]  res_data_nxt;
    logic [TAG_W-1:0]  res_tag_nxt;
    logic              res_err_nxt;

    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign push_req  = '{tag: req_tag, exp: req_exp, base: req_base};

    root_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(req_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign eng_in_valid = (state == ISSUE);
    assign res_valid    = (state == HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            eng_in_data_1 <= '0;
            eng_in_data_2 <= '0;
            res_data      <= '0;
            res_tag       <= '0;
            res_err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            eng_in_data_1 <= op_base_nxt;
            eng_in_data_2 <= op_exp_nxt;
            res_data      <= res_data_nxt;
            res_tag       <= res_tag_nxt;
            res_err       <= res_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        op_base_nxt  = eng_in_data_1;
        op_exp_nxt   = eng_in_data_2;
        res_data_nxt = res_data;
        res_tag_nxt  = res_tag;
        res_err_nxt  = res_err;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    res_tag_nxt = head.tag;
                    // A zeroth root is undefined: report it without bothering the engine.
                    if (head.exp == '0) begin
                        res_err_nxt  = 1'b1;
                        res_data_nxt = '0;
                        state_nxt    = HOLD;
                    end else begin
                        op_base_nxt = head.base;
                        op_exp_nxt  = head.exp;
                        state_nxt   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wait_cnt_nxt = '0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                wait_cnt_nxt = wait_cnt + CNT_W'(1);
                if (eng_out_valid) begin
                    res_data_nxt = eng_out_data;
                    res_err_nxt  = 1'b0;
                    state_nxt    = DRAIN;
                end else if (wait_cnt == WAIT_LAST) begin
                    res_data_nxt = '0;
                    res_err_nxt  = 1'b1;
                    state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                // Engine may hold out_valid several cycles; let it fall before moving on.
                if (!eng_out_valid) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_root_feeder.sv
// Directed bench for root_feeder with a behavioural root engine that answers one cycle after issue.
module tb_root_feeder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_base;
    logic [2:0]  req_exp;
    logic [1:0]  req_tag;
    logic        eng_in_valid;
    logic [9:0]  eng_in_data_1;
    logic [2:0]  eng_in_data_2;
    logic        eng_out_valid;
    logic [19:0] eng_out_data;
    logic        res_valid;
    logic        res_ready;
    logic [19:0] res_data;
    logic [1:0]  res_tag;
    logic        res_err;

    root_feeder #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (1023)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_base      (req_base),
        .req_exp       (req_exp),
        .req_tag       (req_tag),
        .eng_in_valid  (eng_in_valid),
        .eng_in_data_1 (eng_in_data_1),
        .eng_in_data_2 (eng_in_data_2),
        .eng_out_valid (eng_out_valid),
        .eng_out_data  (eng_out_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_tag       (res_tag),
        .res_err       (res_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Engine model configuration and observations.
    int          eng_hold   = 1;
    bit          eng_never  = 1'b0;
    bit          stray_req  = 1'b0;
    int          eng_issues = 0;
    int          hold_left  = 0;
    bit          busy       = 1'b0;
    logic [9:0]  seen_base  = '0;
    logic [2:0]  seen_exp   = '0;

    function automatic logic [19:0] fake_root(input logic [9:0] b, input logic [2:0] e);
        if (b == 10'd27 && e == 3'd3) return 20'h00C00;
        return {e, 7'd0, b};
    endfunction

    // Answers on the cycle after the start pulse; later valid cycles carry corrupted data.
    initial begin
        eng_out_valid = 1'b0;
        eng_out_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eng_out_valid = 1'b0;
                busy          = 1'b0;
            end else begin
                if (eng_out_valid) begin
                    hold_left--;
                    if (hold_left <= 0) eng_out_valid = 1'b0;
                    else                eng_out_data  = ~eng_out_data;
                end else if (busy) begin
                    eng_out_valid = 1'b1;
                    eng_out_data  = fake_root(seen_base, seen_exp);
                    hold_left     = eng_hold;
                    busy          = 1'b0;
                end else if (stray_req) begin
                    eng_out_valid = 1'b1;
                    eng_out_data  = 20'h12345;
                    hold_left     = 1;
                    stray_req     = 1'b0;
                end
                if (eng_in_valid) begin
                    eng_issues++;
                    seen_base = eng_in_data_1;
                    seen_exp  = eng_in_data_2;
                    busy      = !eng_never;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic push_one(input logic [9:0] b, input logic [2:0] e, input logic [1:0] t);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_base  = b;
        req_exp   = e;
        req_tag   = t;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_res(input int max, output int n);
        n = 0;
        while (!res_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_seen", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_fall", {31'd0, res_valid}, 32'd0);
    endtask

    task automatic take_res(input string nm, input logic [1:0] t, input logic [19:0] d, input logic e);
        int n;
        wait_res(2000, n);
        check({nm, "_tag"},  {30'd0, res_tag}, {30'd0, t});
        check({nm, "_data"}, {12'd0, res_data}, {12'd0, d});
        check({nm, "_err"},  {31'd0, res_err}, {31'd0, e});
        accept();
    endtask

    typedef struct {
        logic [9:0]  base;
        logic [2:0]  exp;
        logic [1:0]  tag;
        logic [19:0] data;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int n;
        int iss0;
        bit seen;
        logic [19:0] snap_data;

        vecs[0] = '{10'd27,   3'd3, 2'd1, 20'h00C00, 1'b0, 4};
        vecs[1] = '{10'd5,    3'd0, 2'd2, 20'h00000, 1'b1, 1};
        vecs[2] = '{10'd100,  3'd2, 2'd3, 20'h40064, 1'b0, 4};
        vecs[3] = '{10'd1023, 3'd7, 2'd0, 20'hE03FF, 1'b0, 4};
        vecs[4] = '{10'd0,    3'd1, 2'd1, 20'h20000, 1'b0, 4};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_base  = '0;
        req_exp   = '0;
        req_tag   = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_eng_in_valid", {31'd0, eng_in_valid}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_err", {31'd0, res_err}, 32'd0);
        check("rst_res_data", {12'd0, res_data}, 32'd0);
        check("rst_eng_data", {19'd0, eng_in_data_2, eng_in_data_1}, 32'd0);

        // Single requests, one at a time.
        for (int i = 0; i < 5; i++) begin
            iss0 = eng_issues;
            push_one(vecs[i].base, vecs[i].exp, vecs[i].tag);
            wait_res(50, n);
            check("vec_latency", n, vecs[i].lat);
            check("vec_tag", {30'd0, res_tag}, {30'd0, vecs[i].tag});
            check("vec_data", {12'd0, res_data}, {12'd0, vecs[i].data});
            check("vec_err", {31'd0, res_err}, {31'd0, vecs[i].err});
            check("vec_issues", eng_issues - iss0, (vecs[i].exp != 3'd0) ? 1 : 0);
            if (vecs[i].exp != 3'd0) begin
                check("vec_eng_operands", {19'd0, seen_exp, seen_base}, {19'd0, vecs[i].exp, vecs[i].base});
            end
            accept();
        end

        // Engine valid while idle must be ignored.
        iss0 = eng_issues;
        stray_req = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("stray_no_result", {31'd0, seen}, 32'd0);
        check("stray_no_issue", eng_issues - iss0, 0);

        // Fill the queue behind a held result, then check order of return.
        push_one(10'd9, 3'd2, 2'd2);
        wait_res(50, n);
        check("blk_data", {12'd0, res_data}, 32'h40009);
        push_one(10'd11, 3'd1, 2'd0);
        push_one(10'd22, 3'd2, 2'd1);
        push_one(10'd33, 3'd3, 2'd2);
        push_one(10'd44, 3'd4, 2'd3);
        check("full_ready_low", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b1;
        req_base  = 10'd55;
        req_exp   = 3'd5;
        req_tag   = 2'd1;
        for (int k = 0; k < 3; k++) begin
            check("full_blocked", {31'd0, req_ready}, 32'd0);
            check("blk_tag_stable", {30'd0, res_tag}, 32'd2);
            @(negedge clk);
        end
        accept();
        @(negedge clk);
        check("ready_after_pop", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        take_res("ord0", 2'd0, fake_root(10'd11, 3'd1), 1'b0);
        take_res("ord1", 2'd1, fake_root(10'd22, 3'd2), 1'b0);
        take_res("ord2", 2'd2, fake_root(10'd33, 3'd3), 1'b0);
        take_res("ord3", 2'd3, fake_root(10'd44, 3'd4), 1'b0);
        take_res("ord4", 2'd1, fake_root(10'd55, 3'd5), 1'b0);

        // Engine valid held two cycles, result held back by downstream.
        repeat (2) @(negedge clk);
        eng_hold = 2;
        iss0 = eng_issues;
        push_one(10'd77, 3'd2, 2'd1);
        push_one(10'd88, 3'd3, 2'd2);
        wait_res(50, n);
        check("hold2_latency", n, 4);
        snap_data = res_data;
        check("hold2_data", {12'd0, res_data}, {12'd0, fake_root(10'd77, 3'd2)});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold2_stable", {9'd0, res_valid, res_err, res_tag, res_data},
                  {9'd0, 1'b1, 1'b0, 2'd1, snap_data});
        end
        check("hold2_single_issue", eng_issues - iss0, 1);
        accept();
        take_res("hold2_next", 2'd2, fake_root(10'd88, 3'd3), 1'b0);
        eng_hold = 1;

        // Engine never answers: timeout, then normal service resumes.
        eng_never = 1'b1;
        push_one(10'd50, 3'd4, 2'd3);
        wait_res(1100, n);
        check("timeout_latency", n, 1026);
        check("timeout_err", {31'd0, res_err}, 32'd1);
        check("timeout_data", {12'd0, res_data}, 32'd0);
        check("timeout_tag", {30'd0, res_tag}, 32'd3);
        eng_never = 1'b0;
        accept();
        push_one(10'd60, 3'd2, 2'd0);
        wait_res(50, n);
        check("post_timeout_latency", n, 4);
        check("post_timeout_data", {12'd0, res_data}, {12'd0, fake_root(10'd60, 3'd2)});
        check("post_timeout_err", {31'd0, res_err}, 32'd0);
        accept();

        // Reset while waiting on the engine with two requests queued.
        eng_never = 1'b1;
        push_one(10'd100, 3'd2, 2'd0);
        push_one(10'd200, 3'd3, 2'd1);
        push_one(10'd300, 3'd4, 2'd2);
        repeat (3) @(negedge clk);
        check("pre_rst_operand", {22'd0, eng_in_data_1}, 32'd100);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_valids", {30'd0, eng_in_valid, res_valid}, 32'd0);
        check("mid_rst_res", {9'd0, res_err, res_tag, res_data}, 32'd0);
        check("mid_rst_eng_data", {19'd0, eng_in_data_2, eng_in_data_1}, 32'd0);
        eng_never = 1'b0;
        iss0 = eng_issues;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("mid_rst_no_result", {31'd0, seen}, 32'd0);
        check("mid_rst_no_issue", eng_issues - iss0, 0);
        push_one(10'd64, 3'd6, 2'd3);
        take_res("post_rst", 2'd3, 20'hC0040, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/root_feeder.md
ROOT_FEEDER -- requirements
Module: root_feeder

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, the number of request-queue entries (power of two, at least 2).
REQ-002 The module SHALL have parameter TIMEOUT, default 1023, the maximum engine wait in cycles before an error is reported.
REQ-003 The module SHALL have a single clock and a synchronous, active-low reset; clk and rst_n are listed first below.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The module SHALL have port req_valid, input, 1 bit: upstream request present.
REQ-007 The module SHALL have port req_ready, output, 1 bit: queue not full.
REQ-008 The module SHALL have port req_base, input, 10 bits: unsigned integer radicand.
REQ-009 The module SHALL have port req_exp, input, 3 bits: root order n.
REQ-010 The module SHALL have port req_tag, input, 2 bits: opaque ID returned with the result.
REQ-011 The module SHALL have port eng_in_valid, output, 1 bit: start pulse to the root engine.
REQ-012 The module SHALL have port eng_in_data_1, output, 10 bits: radicand to the engine.
REQ-013 The module SHALL have port eng_in_data_2, output, 3 bits: root order to the engine.
REQ-014 The module SHALL have port eng_out_valid, input, 1 bit: engine result valid.
REQ-015 The module SHALL have port eng_out_data, input, 20 bits: engine result in Q10.10.
REQ-016 The module SHALL have port res_valid, output, 1 bit: result held for downstream.
REQ-017 The module SHALL have port res_ready, input, 1 bit: downstream accepts the result.
REQ-018 The module SHALL have port res_data, output, 20 bits: Q10.10 root, or 0 on error.
REQ-019 The module SHALL have port res_tag, output, 2 bits: tag of the request that produced the result.
REQ-020 The module SHALL have port res_err, output, 1 bit: 1 means bad exponent or engine timeout.

Function
REQ-021 A request SHALL be pushed into the FIFO when req_valid and req_ready are both 1; req_ready SHALL equal !full.
REQ-022 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged; a push into a full queue SHALL never occur.
REQ-023 The FSM SHALL have states IDLE, ISSUE, WAIT, DRAIN and HOLD.
REQ-024 IDLE -> ISSUE SHALL occur when the FIFO is non-empty and the res slot is empty; the head entry SHALL be popped into operand registers on that edge.
REQ-025 If the popped req_exp equals 0, IDLE SHALL go directly to HOLD with res_err=1 and res_data=0, and the engine SHALL NOT be started.
REQ-026 In ISSUE, eng_in_valid SHALL be 1 for exactly one cycle, followed by ISSUE -> WAIT.
REQ-027 eng_in_data_1 and eng_in_data_2 SHALL stay stable from ISSUE until DRAIN exits; the engine samples them throughout computation.
REQ-028 In WAIT, on the first cycle with eng_out_valid=1, eng_out_data SHALL be captured into res_data with res_err=0, followed by WAIT -> DRAIN.
REQ-029 A 10-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; on reaching TIMEOUT the FSM SHALL go to DRAIN with res_err=1 and res_data=0.
REQ-030 In DRAIN, the FSM SHALL wait until eng_out_valid=0 for one full cycle before going to HOLD, since the engine may hold out_valid for more than one cycle.
REQ-031 Any eng_out_valid seen outside WAIT SHALL be ignored.
REQ-032 In HOLD, res_valid SHALL be 1; on res_ready=1 the FSM SHALL go to IDLE and res_valid SHALL fall on the next edge.
REQ-033 res_data, res_tag and res_err SHALL stay stable while res_valid=1 and res_ready=0.
REQ-034 Latency SHALL be: issue 1 cycle after IDLE with data present; res_valid 2 cycles after the engine result (1 capture + 1 drain, minimum).
REQ-035 Results SHALL be returned in request order.

Reset
REQ-036 When rst_n=0 at a clock edge, the following SHALL be cleared:
- FIFO emptied, so req_ready=1
- FSM in IDLE
- eng_in_valid, res_valid, res_err = 0
- eng_in_data_1, eng_in_data_2, res_data, res_tag = 0
- wait counter = 0
REQ-037 A reset applied mid-operation SHALL discard all queued and in-flight requests; the engine shares rst_n and is reset with the feeder.

Structure
REQ-038 Package root_pkg SHALL hold:
- the FSM state enum
- operand, result and tag width constants
- default FIFO_DEPTH and TIMEOUT
REQ-039 The request queue SHALL be sub-module root_req_fifo: synchronous, with push/pop/full/empty ports and a 15-bit entry {tag, exp, base}.

Verification
REQ-040 Base=27, exp=3, tag=1, with an engine model returning 0x00C00 -> exactly one eng_in_valid pulse and res_data=0x00C00, tag=1, err=0.
REQ-041 Exp=0, base=5, tag=2 -> no eng_in_valid pulse and res_valid with data=0, tag=2, err=1.
REQ-042 Four requests pushed back-to-back, then a fifth offered -> req_ready=0 until the first pop; results return in tag order 0,1,2,3.
REQ-043 Engine model never asserts out_valid -> res_err=1 after TIMEOUT=1023 WAIT cycles, and the next request then issues normally.
REQ-044 Engine holds out_valid for 2 cycles and res_ready is held 0 for 5 cycles -> a single capture, res fields stable, no second issue before out_valid falls.
REQ-045 rst_n=0 during WAIT with 2 requests queued -> all outputs return to reset values, the queue is empty, and no result is produced.
